// File: rtl/ws2812_strip_driver.sv
// ws2812_strip_driver: frame-buffered WS2812 chain serialiser with brightness scaling and latch gap
module ws2812_strip_driver #(
  parameter int NUM_LEDS     = 8,
  parameter int T_BIT        = 60,
  parameter int T0H          = 19,
  parameter int T1H          = 38,
  parameter int RESET_CYCLES = 2880,
  parameter int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_rgb,
  input  logic [7:0]    brightness,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          data_out
);
  localparam int TW = $clog2(T_BIT + 1);
  localparam int GW = $clog2(RESET_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, LOAD, BIT, GAP} state_e;
  state_e        state_q, state_d;
  logic [23:0]   pix_q [2**AW];
  logic [23:0]   sr_q, sr_d, pix;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] bit_timer_q, bit_timer_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [AW-1:0] led_idx_q, led_idx_d;
  logic [7:0]    bright_q, bright_d;
  logic          from_rst_q, from_rst_d;
  logic          done_q, done_d;
  function automatic logic [7:0] scl(input logic [7:0] c, input logic [7:0] b);
    return 8'((16'(c) * (16'(b) + 16'd1)) >> 8);
  endfunction
  always_ff @(posedge clk)
    if (wr_en && int'(wr_addr) < NUM_LEDS) pix_q[wr_addr] <= wr_rgb;
  assign pix = pix_q[led_idx_q];
  // gap entered from reset must not report a completed frame
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= GAP;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      bit_timer_q <= '0;
      gap_cnt_q   <= '0;
      led_idx_q   <= '0;
      bright_q    <= '0;
      from_rst_q  <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_timer_q <= bit_timer_d;
      gap_cnt_q   <= gap_cnt_d;
      led_idx_q   <= led_idx_d;
      bright_q    <= bright_d;
      from_rst_q  <= from_rst_d;
      done_q      <= done_d;
    end
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    bit_timer_d = bit_timer_q;
    gap_cnt_d   = gap_cnt_q;
    led_idx_d   = led_idx_q;
    bright_d    = bright_q;
    from_rst_d  = from_rst_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        bright_d  = brightness;
        led_idx_d = '0;
        state_d   = LOAD;
      end
      LOAD: begin
        sr_d        = {scl(pix[15:8], bright_q), scl(pix[23:16], bright_q), scl(pix[7:0], bright_q)};
        bit_cnt_d   = 5'd23;
        bit_timer_d = '0;
        state_d     = BIT;
      end
      BIT: if (bit_timer_q == TW'(T_BIT - 1)) begin
        bit_timer_d = '0;
        if (bit_cnt_q != 5'd0) begin
          sr_d      = sr_q << 1;
          bit_cnt_d = bit_cnt_q - 5'd1;
        end else if (led_idx_q != AW'(NUM_LEDS - 1)) begin
          led_idx_d = led_idx_q + AW'(1);
          state_d   = LOAD;
        end else begin
          gap_cnt_d  = '0;
          from_rst_d = 1'b0;
          state_d    = GAP;
        end
      end else bit_timer_d = bit_timer_q + TW'(1);
      GAP: if (gap_cnt_q == GW'(RESET_CYCLES - 1)) begin
        done_d  = !from_rst_q;
        state_d = IDLE;
      end else gap_cnt_d = gap_cnt_q + GW'(1);
      default: state_d = GAP;
    endcase
  end
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign data_out = (state_q == BIT) && (bit_timer_q < (sr_q[23] ? TW'(T1H) : TW'(T0H)));
endmodule

// File: tb/tb_ws2812_strip_driver.sv
// tb_ws2812_strip_driver: directed checks of the WS2812 chain driver on a 2-pixel, 10-cycle-bit setup
module tb_ws2812_strip_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [23:0] wr_rgb = '0;
  logic [7:0]  brightness = '0;
  logic        start = 1'b0;
  logic        busy, done, data_out;
  int          errors = 0;
  int          checks = 0;

  ws2812_strip_driver #(
    .NUM_LEDS(2), .T_BIT(10), .T0H(3), .T1H(7), .RESET_CYCLES(20), .AW(2)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb),
    .brightness(brightness), .start(start), .busy(busy), .done(done), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic write_pix(input logic [1:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_rgb = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic gap_chk(input string tag);
    logic seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      seen |= done;
      if (i == 19) chk({tag, "_busy_hold"}, 48'(busy), 48'd1);
      if (i == 20) chk({tag, "_busy_fall"}, 48'(busy), 48'd0);
    end
    chk({tag, "_no_done"}, 48'(seen), 48'd0);
  endtask

  // Cycle n is the cycle following the n-th posedge after the start-sampling edge.
  // A late start is always driven so it is sampled on the final GAP edge.
  task automatic tick(inout int cyc, input int st_cyc, input int wr_cyc,
                      input logic [1:0] wa, input logic [23:0] wd);
    @(negedge clk);
    cyc++;
    start   = (cyc == st_cyc) || (cyc == 502);
    wr_en   = (cyc == wr_cyc);
    wr_addr = wa;
    wr_rgb  = wd;
    if (cyc == 1) brightness = 8'hA5;
  endtask

  task automatic frame(input string tag, input logic [7:0] br, input logic [47:0] exp,
                       input int st_cyc, input int wr_cyc, input logic [1:0] wa, input logic [23:0] wd);
    int         cyc = 0;
    logic [9:0] w;
    brightness = br;
    start      = 1'b1;
    for (int p = 0; p < 2; p++) begin
      tick(cyc, st_cyc, wr_cyc, wa, wd);
      chk({tag, "_load"}, {46'd0, data_out, busy}, 48'b01);
      for (int b = 0; b < 24; b++) begin
        for (int t = 0; t < 10; t++) begin
          tick(cyc, st_cyc, wr_cyc, wa, wd);
          w[9-t] = data_out;
        end
        chk($sformatf("%s_p%0d_b%0d", tag, p, b), 48'(w),
            exp[47-24*p-b] ? 48'b1111111000 : 48'b1110000000);
      end
    end
    while (done !== 1'b1 && cyc < 600) tick(cyc, st_cyc, wr_cyc, wa, wd);
    chk({tag, "_done_cycle"}, 48'(cyc), 48'd503);
    chk({tag, "_busy_at_done"}, 48'(busy), 48'd0);
    tick(cyc, st_cyc, wr_cyc, wa, wd);
    chk({tag, "_after_done"}, {46'd0, done, busy}, 48'b00);
    tick(cyc, st_cyc, wr_cyc, wa, wd);
    chk({tag, "_idle"}, 48'(busy), 48'd0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_outputs", {45'd0, busy, done, data_out}, 48'b100);
    @(negedge clk);
    rst = 1'b0;
    gap_chk("rst_gap");
    write_pix(2'd0, {8'd0, 8'd206, 8'd255});
    write_pix(2'd1, {8'd255, 8'd0, 8'd1});
    frame("full", 8'd255, 48'hCE00FF_00FF01, -1, -1, 2'd0, 24'd0);
    frame("half", 8'd127, 48'h67007F_007F00, -1, -1, 2'd0, 24'd0);
    frame("zero", 8'd0, 48'h000000_000000, -1, -1, 2'd0, 24'd0);
    write_pix(2'd3, 24'hFFFFFF);
    frame("live", 8'd255, 48'hCE00FF_341256, 200, 50, 2'd1, 24'h123456);
    frame("loadwr", 8'd255, 48'hCE00FF_341256, -1, 1, 2'd0, 24'hABCDEF);
    brightness = 8'd255;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (102) @(negedge clk);
    chk("abort_high", 48'(data_out), 48'd1);
    #1 rst = 1'b1;
    #1 chk("abort_async", {45'd0, busy, done, data_out}, 48'b100);
    @(negedge clk);
    rst = 1'b0;
    gap_chk("abort_gap");
    frame("recover", 8'd255, 48'hCDABEF_341256, -1, -1, 2'd0, 24'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ws2812_strip_driver.md
# ws2812_strip_driver

Parametrised driver for a chain of NUM_LEDS WS2812-style addressable LEDs on a single one-wire data line. It holds a per-pixel RGB frame buffer written by upstream logic and, on a start pulse, serialises the whole frame in GRB order with programmable bit timing and global brightness scaling. It then holds the line low for the latch gap. It replaces the single-pixel LED driver and sits between the pattern/control logic and the LED output pin.

## Interface
Parameters:
- NUM_LEDS, 8, pixels in the chain; must be ≥1
- T_BIT, 60, clk cycles per data bit (1.25 µs at 48 MHz)
- T0H, 19, high cycles for a 0 bit
- T1H, 38, high cycles for a 1 bit; require 1 ≤ T0H < T1H < T_BIT
- RESET_CYCLES, 2880, low cycles for the latch/reset gap (≥50 µs)
- AW, $clog2(NUM_LEDS) (minimum 1), pixel address width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write wr_rgb into pixel wr_addr this cycle
- wr_addr  in  AW  pixel index; writes with wr_addr ≥ NUM_LEDS are ignored
- wr_rgb  in  24  {R[7:0], G[7:0], B[7:0]}
- brightness  in  8  global scale, sampled on accepted start
- start  in  1  one-cycle request to transmit the frame
- busy  out  1  frame or gap in progress; start is ignored while high
- done  out  1  one-cycle pulse when the frame's latch gap completes
- data_out  out  1  serial line to the first LED

## Operation
- Reset values: data_out=0, done=0, busy=1; state=GAP with done suppressed. The pixel buffer is not cleared.
- States:
  - IDLE: data_out=0, busy=0. When start=1, latch brightness, set led_idx=0, and go to LOAD.
  - LOAD: one cycle, data_out=0. Read pixel[led_idx] and scale each channel to (c*(brightness+1))>>8; this is an 8×9-bit product, keep bits [15:8]. Load a 24-bit shift register with {G,R,B}, set bit_cnt=23 and bit_timer=0, then go to BIT.
  - BIT: data_out=1 while bit_timer < (msb ? T1H : T0H), else 0. bit_timer runs 0..T_BIT-1. At T_BIT-1:
    - bit_cnt>0: shift left, decrement bit_cnt, reset bit_timer.
    - bit_cnt=0 and led_idx<NUM_LEDS-1: increment led_idx, go to LOAD.
    - bit_cnt=0 and led_idx=NUM_LEDS-1: go to GAP.
  - GAP: data_out=0 for RESET_CYCLES cycles. Then go to IDLE. Pulse done in the cycle busy falls, unless GAP was entered from reset.
- Buffer writes are accepted in every state. A write to the pixel being read in LOAD in the same cycle is not seen: LOAD sees the old value. A write to a pixel not yet loaded is transmitted in the current frame.
- Brightness changes during a frame take effect on the next start.
- A start coincident with the final GAP cycle is ignored; busy is still 1 in that cycle.
- Brightness 255 transmits unscaled values. Brightness 0 transmits all zeros.

## Timing
- An accepted start on edge k gives LOAD in cycle k+1 and the first data_out rise in cycle k+2.
- Each pixel takes 1+24·T_BIT cycles. The LOAD cycle lengthens the previous bit's low phase by one cycle, which is within WS2812 tolerance.
- Start edge to done pulse: NUM_LEDS·(1+24·T_BIT)+RESET_CYCLES+1 cycles.
- busy rises in the cycle after the accepted start and falls together with done.
- Reset asserted mid-frame:
  - data_out goes to 0 immediately (asynchronous), and the frame is abandoned.
  - After release, busy stays 1 for RESET_CYCLES cycles with no done pulse, so the strip resynchronises.
- done is never asserted for an aborted frame.

## Test plan
Use NUM_LEDS=2, T_BIT=10, T0H=3, T1H=7, RESET_CYCLES=20, with a 10 ns clk.
- Reset: assert rst mid-sim → data_out=0, busy=1 and done=0 immediately. After release, busy falls 20 cycles later with no done pulse.
- Single frame:
  - Stimulus: pixel0={0,206,255}, pixel1={255,0,1}, brightness=255, start.
  - Bit stream: 0xCE,0x00,0xFF then 0x00,0xFF,0x01, MSB first. Each 1 bit is 7 high/3 low, each 0 bit is 3 high/7 low.
  - done pulses exactly 503 cycles after the start edge.
- Brightness: brightness=127 with pixel0={0,206,255} → transmitted G=103, R=0, B=127. brightness=0 → all 48 bits are 0-codes.
- Ignored start and live writes:
  - Pulse start while busy → no effect on timing or count.
  - Write pixel1 during pixel0's bits → pixel1's new value is transmitted.
  - Write wr_addr=3 → ignored.
- Reset mid-frame: assert rst at bit 10 of pixel0 → data_out drops asynchronously, no done pulse. The post-reset gap completes, and a new start transmits a full, correct frame.
